// File: rtl/uart_tx_arbiter.sv
// Grants the shared UART transmitter to one byte-stream requester per message and paces bytes on tx_done.
// Build option: define TXARB_FIXED_PRIO_EN for fixed-priority arbitration (lowest index wins); default is round-robin.
module uart_tx_arbiter #(
  parameter int NREQ     = 3,
  parameter int IDLE_TMO = 1024,
  parameter int TMO_W    = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ-1:0]   i_last,
  input  logic [8*NREQ-1:0] i_byte,
  output logic [NREQ-1:0]   o_ack,
  output logic [NREQ-1:0]   o_grant,
  output logic [7:0]        o_byte,
  output logic              o_byte_v,
  input  logic              i_tx_active,
  input  logic              i_tx_done,
  output logic              o_busy,
  output logic              o_tmo
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(IDLE_TMO - 1);
  localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, HOLD} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              last_q, last_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        byte_q, byte_d;
  logic              byte_v_q, byte_v_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              tmo_q, tmo_d;
  logic              busy_q;

  logic [7:0]        req_byte [NREQ];
  logic [PTR_W-1:0]  win_idx;
  logic [PTR_W-1:0]  next_ptr;

  for (genvar g = 0; g < NREQ; g++) begin : g_bytes
    assign req_byte[g] = i_byte[8*g +: 8];
  end

  // First requester with a pending byte at or after base, wrapping modulo NREQ.
  function automatic logic [PTR_W-1:0] pick(input logic [NREQ-1:0] req,
                                            input logic [PTR_W-1:0] base);
    logic [PTR_W-1:0] idx;
    int               k;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = int'(base) + i;
      if (k >= NREQ) k = k - NREQ;
      if (req[k]) idx = PTR_W'(k);
    end
    return idx;
  endfunction

  assign win_idx = pick(i_req, ptr_q);

`ifdef TXARB_FIXED_PRIO_EN
  // Pointer stays at zero, so the scan always starts at the echo path.
  assign next_ptr = '0;
`else
  assign next_ptr = (owner_q == PTR_MAX) ? '0 : owner_q + PTR_W'(1);
`endif

  // NOTE: every *_d signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    last_d   = last_q;
    cnt_d    = '0;
    byte_d   = byte_q;
    byte_v_d = 1'b0;
    ack_d    = '0;
    tmo_d    = tmo_q;
    case (state_q)
      IDLE: begin
        if (|i_req) begin
          owner_d = win_idx;
          grant_d = NREQ'(1) << win_idx;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!i_tx_active) begin
          byte_d         = req_byte[owner_q];
          byte_v_d       = 1'b1;
          ack_d[owner_q] = 1'b1;
          last_d         = i_last[owner_q];
          state_d        = WAIT;
        end
      end
      WAIT: begin
        if (i_tx_done) begin
          if (last_q) begin
            grant_d = '0;
            ptr_d   = next_ptr;
            state_d = IDLE;
          end else if (i_req[owner_q]) begin
            state_d = SEND;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // Owner keeps the lock while quiet, but only for IDLE_TMO cycles.
        if (i_req[owner_q]) begin
          state_d = SEND;
        end else if (cnt_q == TMO_LAST) begin
          grant_d = '0;
          ptr_d   = next_ptr;
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      ptr_q    <= '0;
      last_q   <= 1'b0;
      cnt_q    <= '0;
      byte_q   <= '0;
      byte_v_q <= 1'b0;
      ack_q    <= '0;
      tmo_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      byte_q   <= byte_d;
      byte_v_q <= byte_v_d;
      ack_q    <= ack_d;
      tmo_q    <= tmo_d;
      busy_q   <= |grant_d;
    end
  end

  assign o_grant  = grant_q;
  assign o_ack    = ack_q;
  assign o_byte   = byte_q;
  assign o_byte_v = byte_v_q;
  assign o_busy   = busy_q;
  assign o_tmo    = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: message-level model checked every cycle, plus directed literal expectations.
module tb_uart_tx_arbiter;
  localparam int NREQ     = 3;
  localparam int IDLE_TMO = 1024;
  localparam int TMO_W    = 11;
`ifdef TXARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   i_req = '0;
  logic [NREQ-1:0]   i_last = '0;
  logic [8*NREQ-1:0] i_byte = '0;
  logic              i_tx_active = 1'b0;
  logic              i_tx_done = 1'b0;
  logic [NREQ-1:0]   o_ack, o_grant;
  logic [7:0]        o_byte;
  logic              o_byte_v, o_busy, o_tmo;

  uart_tx_arbiter #(.NREQ(NREQ), .IDLE_TMO(IDLE_TMO), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_last(i_last), .i_byte(i_byte),
    .o_ack(o_ack), .o_grant(o_grant), .o_byte(o_byte), .o_byte_v(o_byte_v),
    .i_tx_active(i_tx_active), .i_tx_done(i_tx_done), .o_busy(o_busy), .o_tmo(o_tmo)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- message-level reference model ----------------
  int              m_owner = -1;
  int              m_ptr = 0;
  int              m_gap = 0;
  int              m_win, m_k;
  bit              m_armed = 0, m_flight = 0, m_quiet = 0, m_last = 0;
  logic [7:0]      e_byte = '0;
  bit              e_v = 0, e_tmo = 0;
  logic [NREQ-1:0] e_ack = '0;
  logic [NREQ-1:0] e_grant;
  bit              e_busy;

  task automatic m_release();
    m_ptr   = FIXED ? 0 : (m_owner + 1) % NREQ;
    m_owner = -1;
    m_quiet = 0;
  endtask

  always @(posedge clk) begin
    e_v   = 0;
    e_ack = '0;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_gap = 0;
      m_armed = 0; m_flight = 0; m_quiet = 0; m_last = 0;
      e_byte = '0; e_tmo = 0;
    end else if (m_owner < 0) begin
      m_win = -1;
      for (int i = NREQ - 1; i >= 0; i--) begin
        m_k = (m_ptr + i) % NREQ;
        if (i_req[m_k]) m_win = m_k;
      end
      if (m_win >= 0) begin
        m_owner = m_win;
        m_armed = 1;
      end
    end else if (m_armed) begin
      if (!i_tx_active) begin
        e_byte         = i_byte[8*m_owner +: 8];
        e_v            = 1;
        e_ack[m_owner] = 1'b1;
        m_last         = i_last[m_owner];
        m_armed        = 0;
        m_flight       = 1;
      end
    end else if (m_flight) begin
      if (i_tx_done) begin
        m_flight = 0;
        if (m_last) m_release();
        else if (i_req[m_owner]) m_armed = 1;
        else begin m_quiet = 1; m_gap = 0; end
      end
    end else if (m_quiet) begin
      if (i_req[m_owner]) begin
        m_quiet = 0;
        m_armed = 1;
      end else begin
        m_gap++;
        if (m_gap == IDLE_TMO) begin
          m_release();
          e_tmo = 1;
        end
      end
    end
    e_grant = (m_owner < 0) ? '0 : NREQ'(1) << m_owner;
    e_busy  = (m_owner >= 0);
  end

  always @(negedge clk) begin
    if (chk_en)
      check($sformatf("outputs c%0d", cyc),
            {o_grant, o_busy, o_byte, o_byte_v, o_ack, o_tmo},
            {e_grant, e_busy, e_byte, e_v, e_ack, e_tmo});
  end

  // ---------------- event monitor ----------------
  logic [7:0]      byte_log[$];
  int              strobe_cyc[$];
  logic [NREQ-1:0] strobe_grant[$];
  int              ack_log[$];
  int              ack_cyc[$];
  int              grant_cyc = 0;
  logic [NREQ-1:0] mon_prev = '0;

  always @(negedge clk) begin
    if (o_byte_v === 1'b1) begin
      byte_log.push_back(o_byte);
      strobe_cyc.push_back(cyc);
      strobe_grant.push_back(o_grant);
    end
    for (int k = 0; k < NREQ; k++)
      if (o_ack[k] === 1'b1) begin
        ack_log.push_back(k);
        ack_cyc.push_back(cyc);
      end
    if (o_grant !== '0 && mon_prev === '0) grant_cyc = cyc;
    mon_prev = o_grant;
  end

  task automatic clear_logs();
    byte_log.delete(); strobe_cyc.delete(); strobe_grant.delete();
    ack_log.delete(); ack_cyc.delete();
  endtask

  // ---------------- requesters and TX core ----------------
  typedef struct {
    logic [7:0] b;
    bit         last;
    int         gap;
  } ent_t;

  ent_t            rq [NREQ][$];
  int              gap_cnt [NREQ];
  int              tx_t = 4;
  int              tx_cnt = 0;
  int              stall_cnt = 0;
  bit              stall_arm = 0;
  logic [NREQ-1:0] step_prev_g = '0;

  task automatic push(input int k, input logic [7:0] b, input bit last, input int gap);
    ent_t e;
    e.b = b; e.last = last; e.gap = gap;
    rq[k].push_back(e);
    if (rq[k].size() == 1) gap_cnt[k] = gap;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (stall_arm && o_grant != '0 && step_prev_g == '0) begin
      stall_cnt = 5;
      stall_arm = 0;
    end else if (stall_cnt > 0) begin
      stall_cnt--;
    end
    step_prev_g = o_grant;
    i_tx_done = 1'b0;
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) i_tx_done = 1'b1;
    end
    if (o_byte_v) tx_cnt = tx_t;
    i_tx_active = (tx_cnt > 0) || (stall_cnt > 0);
    for (int k = 0; k < NREQ; k++) begin
      if (i_req[k] && o_ack[k]) begin
        void'(rq[k].pop_front());
        i_req[k] = 1'b0;
        if (rq[k].size() > 0) gap_cnt[k] = rq[k][0].gap;
      end
      if (!i_req[k] && rq[k].size() > 0) begin
        if (gap_cnt[k] > 0) gap_cnt[k]--;
        else begin
          i_req[k]         = 1'b1;
          i_byte[8*k +: 8] = rq[k][0].b;
          i_last[k]        = rq[k][0].last;
        end
      end
    end
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int k = 0; k < NREQ; k++) if (rq[k].size() > 0) p = 1'b1;
    return p || (i_req != '0) || o_busy || (tx_cnt > 0) || (stall_cnt > 0);
  endfunction

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (n < budget && pending()) begin
      step();
      n++;
    end
    check({name, " drained"}, 32'(n < budget), 1);
  endtask

  // ---------------- directed sequence ----------------
  int n, t_tmo;

  initial begin
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    check("reset grant", o_grant, 0);
    check("reset busy", o_busy, 0);
    check("reset strobe", o_byte_v, 0);
    check("reset tmo", o_tmo, 0);
    rst = 1'b0;

    // Simultaneous req0/req2 with pointer 0
    clear_logs();
    push(0, 8'h11, 1, 0);
    push(2, 8'h22, 1, 0);
    drain("pair ptr0", 200);
    check("ptr0 ack count", ack_log.size(), 2);
    check("ptr0 first", ack_log[0], 0);
    check("ptr0 second", ack_log[1], 2);
    check("ptr0 byte0", byte_log[0], 8'h11);

    // Move pointer to 1, then simultaneous req0/req2 again
    push(0, 8'h33, 1, 0);
    drain("ptr move", 200);
    clear_logs();
    push(0, 8'h44, 1, 0);
    push(2, 8'h55, 1, 0);
    drain("pair ptr1", 200);
    check("ptr1 first", ack_log[0], FIXED ? 0 : 2);
    check("ptr1 second", ack_log[1], FIXED ? 2 : 0);
    check("ptr1 first byte", byte_log[0], FIXED ? 8'h44 : 8'h55);

    // Req1 sends "AB\n", TX takes 10 cycles, next byte always ready
    tx_t = 10;
    clear_logs();
    push(1, 8'h41, 0, 0);
    push(1, 8'h42, 0, 0);
    push(1, 8'h0A, 1, 0);
    drain("msg AB", 300);
    check("AB ack count", ack_log.size(), 3);
    check("AB byte0", byte_log[0], 8'h41);
    check("AB byte1", byte_log[1], 8'h42);
    check("AB byte2", byte_log[2], 8'h0A);
    check("AB ack owner", ack_log[2], 1);
    check("AB grant at strobe0", strobe_grant[0], 3'b010);
    check("AB grant at strobe2", strobe_grant[2], 3'b010);
    check("AB spacing 0-1", strobe_cyc[1] - strobe_cyc[0], 12);
    check("AB spacing 1-2", strobe_cyc[2] - strobe_cyc[1], 12);
    check("AB grant after", o_grant, 0);

    // Req2 goes quiet mid-message; req1 waits behind it
    tx_t = 4;
    clear_logs();
    push(2, 8'h61, 0, 0);
    push(2, 8'h62, 1, 1100);
    step();
    step();
    push(1, 8'h71, 1, 0);
    n = 0;
    while (!o_tmo && n < 1300) begin
      step();
      n++;
    end
    t_tmo = cyc;
    check("tmo set", o_tmo, 1);
    check("tmo grant released", o_grant, 0);
    check("tmo timing", t_tmo - ack_cyc[0], 4 + 1 + IDLE_TMO);
    drain("timeout", 1500);
    check("tmo order 0", ack_log[0], 2);
    check("tmo order 1", ack_log[1], 1);
    check("tmo order 2", ack_log[2], 2);
    check("tmo next byte", byte_log[1], 8'h71);
    check("tmo sticky", o_tmo, 1);

    // Reset while req1 waits for tx_done mid-message
    tx_t = 8;
    clear_logs();
    push(1, 8'h51, 0, 0);
    push(1, 8'h52, 1, 0);
    n = 0;
    while (!o_ack[1] && n < 50) begin
      step();
      n++;
    end
    check("first ack before rst", o_ack[1], 1);
    step();
    step();
    rst = 1'b1;
    step();
    check("rst grant", o_grant, 0);
    check("rst busy", o_busy, 0);
    check("rst strobe", o_byte_v, 0);
    check("rst ack", o_ack, 0);
    check("rst byte", o_byte, 0);
    check("rst tmo", o_tmo, 0);
    rst = 1'b0;
    clear_logs();
    drain("after rst", 200);
    check("after rst ack count", ack_log.size(), 1);
    check("after rst owner", ack_log[0], 1);
    check("after rst byte", byte_log[0], 8'h52);

    // TX core busy for 5 cycles when the grant appears
    tx_t = 4;
    clear_logs();
    stall_arm = 1'b1;
    push(0, 8'h77, 1, 0);
    drain("stall", 200);
    check("stall delay", strobe_cyc[0] - grant_cyc, 6);
    check("stall ack count", ack_log.size(), 1);
    check("stall byte", byte_log[0], 8'h77);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between several byte-stream requesters in the terminal design, such as echo, screen refresh and cursor/status updates.
Grants the transmitter to one requester for a whole message, paces bytes with the transmitter's done strobe, and returns a per-byte acknowledge.
Sits between the terminal-buffer command engines and the serial TX core.

Parameters:
NREQ, 3, number of requesters (2..8); requester index 0 is the echo path.
IDLE_TMO, 1024, cycles an owner may leave its request low mid-message before the grant is forcibly released.
TMO_W, 11, width of the timeout counter; must satisfy 2^TMO_W > IDLE_TMO.

Ports:
clk  in  1  clock
rst  in  1  reset
i_req  in  NREQ  per-requester "byte available"; held until the matching o_ack
i_last  in  NREQ  qualifies i_req: the current byte ends that requester's message
i_byte  in  8*NREQ  byte data; requester k occupies bits [8k+7:8k]
o_ack  out  NREQ  one-cycle pulse: the granted requester's byte has been taken
o_grant  out  NREQ  one-hot current owner; all zero when free
o_byte  out  8  byte to the TX core
o_byte_v  out  1  one-cycle strobe to the TX core
i_tx_active  in  1  TX core is shifting a byte
i_tx_done  in  1  TX core finished a byte (one-cycle pulse)
o_busy  out  1  high whenever o_grant is non-zero
o_tmo  out  1  sticky flag, set by a timeout release; cleared only by rst

Behaviour:
- Reset: rst is synchronous and active-high; clk is the clock. All outputs are 0, state is IDLE, round-robin pointer is 0, timeout counter is 0.
- Reset mid-message aborts immediately: no o_ack, no o_byte_v after the reset cycle. The owner's pending byte is not consumed.
- All outputs are registered.
- States:
  - IDLE: if any i_req, select a winner (round-robin: first requester at or after pointer, wrapping modulo NREQ). Latch o_grant and go to SEND. Otherwise stay.
  - SEND: if i_tx_active, stall in SEND. Else register o_byte = owner's byte, o_byte_v = 1, o_ack[owner] = 1, latch last = i_last[owner], and go to WAIT. The strobe and ack are visible for exactly one cycle.
  - WAIT: hold o_byte, keep o_byte_v = 0 and wait for i_tx_done.
    - On i_tx_done with last = 1: clear o_grant, set pointer = owner + 1 (mod NREQ), go to IDLE.
    - On i_tx_done with last = 0: go to SEND if i_req[owner] is high, else go to HOLD.
  - HOLD: the owner keeps the grant while its request is low; the counter increments every cycle.
    - i_req[owner] high: clear the counter, go to SEND.
    - Counter reaches IDLE_TMO: release the grant, set o_tmo, advance the pointer, go to IDLE.
- Latency: i_req rising in IDLE (cycle 0) → o_grant at cycle 1 → o_byte_v/o_ack at cycle 2.
  - Minimum byte period is 2 cycles plus the TX time.
- Requesters must not change i_byte or i_last while i_req is high and o_ack has not yet pulsed. Violations are ignored, with no error.
- Other requesters' i_req during an owned message is never acknowledged and never preempts.
- i_tx_done outside WAIT is ignored.
- Simultaneous i_tx_done and the owner's i_req in WAIT with last = 0 → SEND with no bubble.
- NREQ = 1 degenerates to a pass-through with a message lock.

Optional Feature:
TXARB_FIXED_PRIO_EN:
- Defined: arbitration in IDLE is fixed priority, lowest index wins (echo first). The pointer is unused and held at 0. Messages are still never preempted.
- Undefined: round-robin as above.

Test Plan:
- Req1 sends a 3-byte message "AB\n" with i_last on "\n"; TX done 10 cycles after each strobe → o_byte sequence 0x41, 0x42, 0x0A; three o_ack[1] pulses; o_grant = 3'b010 throughout; then 0.
- Req0 and req2 assert in the same cycle, each sending a 1-byte message, pointer = 0 → req0 served, then req2. Repeat with pointer = 1 → req2 first. With TXARB_FIXED_PRIO_EN → req0 always first.
- Req2 sends byte 1 of 2 (i_last = 0), then drops i_req for 1024 cycles → grant released at the timeout, o_tmo = 1, a pending req1 is granted next.
- i_tx_active held high for 5 cycles on entry to SEND → o_byte_v delayed exactly 5 cycles; no lost or duplicated ack.
- rst asserted in WAIT while req1 is mid-message → the next cycle shows all outputs 0 and o_tmo = 0. After release, req1 regains the grant only via a fresh arbitration.
- Back-to-back bytes with i_tx_done coincident with i_req → strobe spacing equals TX time + 2 cycles, with no extra bubble.
